// File: rtl/l2_request_queue_if.sv
// Request/next-level handshake bundle for l2_request_queue.
// slave = queue side; master = L1 issue side plus next-level acceptor.
interface l2_request_queue_if #(
  parameter int AW = 26
);
  logic          req;
  logic [1:0]    cmd_in;
  logic [AW-1:0] add_in;
  logic          l2_valid;
  logic [1:0]    l2_cmd;
  logic [AW-1:0] l2_add;
  logic          l2_ready;

  modport slave (
    input  req, cmd_in, add_in, l2_ready,
    output l2_valid, l2_cmd, l2_add
  );

  modport master (
    output req, cmd_in, add_in, l2_ready,
    input  l2_valid, l2_cmd, l2_add
  );
endinterface

// File: rtl/l2_request_queue.sv
// L1-to-next-level request queue with read/write/drop/high-water statistics.
// Optional macro COALESCE_EN absorbs a request identical to the queued tail entry.
module l2_request_queue #(
  parameter int DEPTH = 8,
  parameter int PTRW  = 3,
  parameter int AW    = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  l2_request_queue_if.slave    bus,
  output logic                 full,
  output logic [PTRW:0]        level,
  output logic [31:0]          reads,
  output logic [31:0]          writes,
  output logic [31:0]          drops,
  output logic [PTRW:0]        high_water
`ifdef COALESCE_EN
  ,
  output logic [31:0]          coalesced
`endif
);

  logic [1:0]      mem_cmd [DEPTH];
  logic [AW-1:0]   mem_add [DEPTH];
  logic [PTRW-1:0] wptr, rptr;
  logic [PTRW:0]   count, count_nxt;
  logic [AW-1:0]   add_hold;
  logic            cmd_ok, deq, absorb, enq, drop;

  assign cmd_ok = bus.req && (bus.cmd_in == 2'b01 || bus.cmd_in == 2'b10);
  assign deq    = (count != '0) && bus.l2_ready;
  assign full   = (count == (PTRW+1)'(DEPTH));
  assign level  = count;

`ifdef COALESCE_EN
  logic [PTRW-1:0] tail;
  assign tail = wptr - 1'b1;
  // The tail is not absorbable when it is the sole entry leaving this cycle.
  assign absorb = cmd_ok && (count != '0) && !(deq && count == (PTRW+1)'(1))
                  && mem_cmd[tail] == bus.cmd_in && mem_add[tail] == bus.add_in;
`else
  assign absorb = 1'b0;
`endif

  assign enq  = cmd_ok && !absorb && (!full || deq);
  assign drop = cmd_ok && !absorb && full && !deq;

  always_comb begin
    count_nxt = count + (PTRW+1)'(enq) - (PTRW+1)'(deq);
  end

  // Empty queue keeps presenting the last dequeued address rather than stale storage.
  assign bus.l2_valid = (count != '0);
  assign bus.l2_cmd   = bus.l2_valid ? mem_cmd[rptr] : '0;
  assign bus.l2_add   = bus.l2_valid ? mem_add[rptr] : add_hold;

  always_ff @(posedge clk) begin
    if (enq && !clr) begin
      mem_cmd[wptr] <= bus.cmd_in;
      mem_add[wptr] <= bus.add_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      add_hold   <= '0;
      reads      <= '0;
      writes     <= '0;
      drops      <= '0;
      high_water <= '0;
`ifdef COALESCE_EN
      coalesced  <= '0;
`endif
    end else if (clr) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      add_hold   <= '0;
      reads      <= '0;
      writes     <= '0;
      drops      <= '0;
      high_water <= '0;
`ifdef COALESCE_EN
      coalesced  <= '0;
`endif
    end else begin
      count <= count_nxt;
      if (count_nxt > high_water)
        high_water <= count_nxt;
      if (enq)
        wptr <= wptr + 1'b1;
      if (deq) begin
        rptr     <= rptr + 1'b1;
        add_hold <= mem_add[rptr];
      end
      if ((enq || absorb) && bus.cmd_in == 2'b01)
        reads <= reads + 32'd1;
      if ((enq || absorb) && bus.cmd_in == 2'b10)
        writes <= writes + 32'd1;
      if (drop)
        drops <= drops + 32'd1;
`ifdef COALESCE_EN
      if (absorb)
        coalesced <= coalesced + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_l2_request_queue.sv
// Scoreboard bench for l2_request_queue: queue-based reference model, decoupled dequeue monitor.
module tb_l2_request_queue;
  localparam int DEPTH = 8;
  localparam int PTRW  = 3;
  localparam int AW    = 26;

  logic clk = 1'b0;
  logic rst, clr;
  logic            full;
  logic [PTRW:0]   level, high_water;
  logic [31:0]     reads, writes, drops;
`ifdef COALESCE_EN
  logic [31:0]     coalesced;
`endif

  always #5 clk = ~clk;

  l2_request_queue_if #(.AW(AW)) bus ();

  l2_request_queue #(.DEPTH(DEPTH), .PTRW(PTRW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .bus        (bus),
    .full       (full),
    .level      (level),
    .reads      (reads),
    .writes     (writes),
    .drops      (drops),
    .high_water (high_water)
`ifdef COALESCE_EN
    ,
    .coalesced  (coalesced)
`endif
  );

  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] add;
  } ent_t;

  ent_t          mq[$];
  ent_t          exp_q[$];
  int unsigned   m_reads, m_writes, m_drops, m_coal, m_hw;
  logic [AW-1:0] m_last;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_reads = 0; m_writes = 0; m_drops = 0; m_coal = 0; m_hw = 0;
    m_last = '0;
  endtask

  task automatic model_step(input logic r, input logic [1:0] c, input logic [AW-1:0] a,
                            input logic rdy, input logic cl);
    bit   ok, d, ab;
    ent_t n;
    if (cl) begin
      model_reset();
      return;
    end
    n.cmd = c; n.add = a;
    ok = r && (c == 2'b01 || c == 2'b10);
    d  = (mq.size() > 0) && rdy;
    ab = 1'b0;
`ifdef COALESCE_EN
    if (ok && mq.size() > 0 && mq[$] == n && !(d && mq.size() == 1)) ab = 1'b1;
`endif
    if (ok && !ab && mq.size() == DEPTH && !d) begin
      m_drops++;
      ok = 1'b0;
    end
    if (d) begin
      exp_q.push_back(mq[0]);
      m_last = mq[0].add;
      void'(mq.pop_front());
    end
    if (ok) begin
      if (c == 2'b01) m_reads++; else m_writes++;
      if (ab) m_coal++; else mq.push_back(n);
    end
    if (mq.size() > m_hw) m_hw = mq.size();
  endtask

  task automatic check_state();
    chk("level", level, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("l2_valid", bus.l2_valid, mq.size() != 0);
    chk("reads", reads, m_reads);
    chk("writes", writes, m_writes);
    chk("drops", drops, m_drops);
    chk("high_water", high_water, m_hw);
`ifdef COALESCE_EN
    chk("coalesced", coalesced, m_coal);
`endif
    if (mq.size() > 0) begin
      chk("head_cmd", bus.l2_cmd, mq[0].cmd);
      chk("head_add", bus.l2_add, mq[0].add);
    end else begin
      chk("idle_cmd", bus.l2_cmd, 2'b00);
      chk("idle_add", bus.l2_add, m_last);
    end
  endtask

  task automatic cycle(input logic r, input logic [1:0] c, input logic [AW-1:0] a,
                       input logic rdy, input logic cl);
    bus.req = r; bus.cmd_in = c; bus.add_in = a; bus.l2_ready = rdy; clr = cl;
    model_step(r, c, a, rdy, cl);
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Monitor: every accepted head must match the next predicted transfer.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (!rst && !clr && bus.l2_valid && bus.l2_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_deq: got %0h/%0h expected none", bus.l2_cmd, bus.l2_add);
      end else begin
        e = exp_q.pop_front();
        chk("deq_cmd", bus.l2_cmd, e.cmd);
        chk("deq_add", bus.l2_add, e.add);
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0;
    bus.req = 1'b0; bus.cmd_in = 2'b00; bus.add_in = '0; bus.l2_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_state();

    // Latency and order
    cycle(1'b1, 2'b01, 26'h0000040, 1'b0, 1'b0);
    chk("lat_valid", bus.l2_valid, 1'b1);
    cycle(1'b1, 2'b10, 26'h0000080, 1'b0, 1'b0);
    chk("order_level", level, 2);
    cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);
    chk("order_head2", bus.l2_add, 26'h0000080);
    cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);
    chk("order_empty", bus.l2_valid, 1'b0);

    // Full, drop, simultaneous at full, drain
    cycle(1'b0, 2'b00, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 2'b01, AW'(32'h100 + i), 1'b0, 1'b0);
    chk("full_level", level, 8);
    chk("full_drops", drops, 2);
    chk("full_reads", reads, 8);
    chk("full_hw", high_water, 8);
    cycle(1'b1, 2'b10, 26'h0000999, 1'b1, 1'b0);
    chk("simul_level", level, 8);
    chk("simul_drops", drops, 2);
    for (int i = 0; i < 9; i++)
      cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);

    // Invalid commands and clr with req
    cycle(1'b1, 2'b11, 26'h0000123, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 26'h0000124, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 26'h0000125, 1'b0, 1'b1);
    chk("clr_reads", reads, 0);

    // Asynchronous reset mid-stream at level 5
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 2'b10, AW'(32'h200 + i), 1'b0, 1'b0);
    bus.req = 1'b0; bus.l2_ready = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    check_state();
    @(posedge clk);
    #1 rst = 1'b0;
    check_state();

`ifdef COALESCE_EN
    cycle(1'b1, 2'b01, 26'h0001234, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 26'h0001234, 1'b0, 1'b0);
    chk("coal_level", level, 1);
    chk("coal_count", coalesced, 1);
    cycle(1'b1, 2'b01, 26'h0001235, 1'b0, 1'b0);
    chk("coal_level2", level, 2);
`endif

    // Randomized traffic over a small address pool to exercise wrap, drops and matches
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
            AW'(32'h1000 + $urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) == 0);

    cycle(1'b0, 2'b00, '0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
